// File: rtl/neuron_mac_pkg.sv
// Shared definitions for the neuron MAC and the downstream sigmoid stage,
// so both sides agree on operand widths and the activation address format.
// Optional feature macro: NEURON_BIAS_EN (adds the product-aligned bias input).
package neuron_mac_pkg;

  localparam int NUM_WEIGHT   = 784;
  localparam int DATA_WIDTH   = 16;
  localparam int SIG_IN_WIDTH = 10;
  localparam int OUT_SHIFT    = 20;

  // Position tags carried alongside each product through the pipeline
  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  // Pair counter width; at least one bit even for tiny vectors
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_mac_sat_add.sv
// Combinational signed saturating adder. Overflow only happens when both
// operands share a sign and the wrapped sum does not; then clamp to the rail
// on the operands' side.
module sat_add #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y
);

  logic signed [W-1:0] w_sum;
  logic                w_ovf;
  logic signed [W-1:0] w_max;
  logic signed [W-1:0] w_min;

  assign w_sum = i_a + i_b;
  assign w_max = {1'b0, {(W-1){1'b1}}};
  assign w_min = {1'b1, {(W-1){1'b0}}};

  // Select wrapped sum or the rail on the operands' side
  always_comb begin
    w_ovf = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
    o_y   = w_sum;
    if (w_ovf) begin
      o_y = i_a[W-1] ? w_min : w_max;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate front end: three-stage pipeline
// (multiply/tag, saturating accumulate, bias/requantise) feeding the sigmoid
// lookup with a two's-complement address.
// Optional feature macro: NEURON_BIAS_EN (biasValue port, added in stage 3).
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int numWeight  = NUM_WEIGHT,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int sigInWidth = SIG_IN_WIDTH,
  parameter int outShift   = OUT_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [dataWidth-1:0]   myinput,
  input  logic signed [dataWidth-1:0]   weightValue,
  input  logic                          myinputValid,
`ifdef NEURON_BIAS_EN
  input  logic signed [2*dataWidth-1:0] biasValue,
`endif
  output logic signed [sigInWidth-1:0]  sum_out,
  output logic                          out_valid
);

  localparam int ACC_W = 2 * dataWidth;
  localparam int CNT_W = cnt_width(numWeight);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(numWeight - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(2 ** (sigInWidth - 1) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [CNT_W-1:0]          r_cnt;
  logic                      r_v1;
  tag_t                      r_tag;
  logic signed [ACC_W-1:0]   r_mul;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_fin;
  logic signed [sigInWidth-1:0] r_sum_out;
  logic                      r_out_valid;

  logic signed [ACC_W-1:0]   w_mul;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [ACC_W-1:0]   w_bias;
  logic signed [ACC_W-1:0]   w_final;
  logic signed [ACC_W-1:0]   w_shifted;
  logic signed [sigInWidth-1:0] w_req;

  assign w_mul = myinput * weightValue;

`ifdef NEURON_BIAS_EN
  assign w_bias = biasValue;
`else
  assign w_bias = '0;
`endif

  sat_add #(.W(ACC_W)) u_sat_acc (
    .i_a (r_acc),
    .i_b (r_mul),
    .o_y (w_acc_sum)
  );

  sat_add #(.W(ACC_W)) u_sat_bias (
    .i_a (r_acc),
    .i_b (w_bias),
    .o_y (w_final)
  );

  assign w_shifted = w_final >>> outShift;

  // Clamp the shifted sum into the activation address range
  always_comb begin
    w_req = w_shifted[sigInWidth-1:0];
    if (w_shifted > OUT_MAX) begin
      w_req = OUT_MAX[sigInWidth-1:0];
    end else if (w_shifted < OUT_MIN) begin
      w_req = OUT_MIN[sigInWidth-1:0];
    end
  end

  // Stage 1: register product, tag first/last pair, advance wrapping counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_v1  <= 1'b0;
      r_tag <= '0;
      r_mul <= '0;
    end else begin
      r_v1 <= myinputValid;
      if (myinputValid) begin
        r_mul       <= w_mul;
        r_tag.first <= (r_cnt == '0);
        r_tag.last  <= (r_cnt == LAST_CNT);
        r_cnt       <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: first pair loads the accumulator so vectors never carry over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_fin <= 1'b0;
    end else begin
      r_fin <= r_v1 && r_tag.last;
      if (r_v1) begin
        r_acc <= r_tag.first ? r_mul : w_acc_sum;
      end
    end
  end

  // Stage 3: publish the requantised sum with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_fin;
      if (r_fin) begin
        r_sum_out <= w_req;
      end
    end
  end

  assign sum_out   = r_sum_out;
  assign out_valid = r_out_valid;

endmodule
